// File: rtl/lfsr_sched_pkg.sv
// Shared types and constants for the LFSR job scheduler.
package lfsr_sched_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StResp
    } state_e;

endpackage

// File: rtl/lfsr_rr_arb.sv
// Two-way round-robin arbiter; the last-grant pointer moves only on advance.
module lfsr_rr_arb
    import lfsr_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    // High when requester 1 was served last; reset value favours requester 0.
    logic last_q;

    always_comb begin
        grant = '0;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/lfsr_sched.sv
// Schedules seed/advance jobs from two requesters onto one shared LFSR.
// Define LFSR_SCHED_ZSEED_FIX_EN to run zero seeds as all-ones instead of rejecting them.
module lfsr_sched
    import lfsr_sched_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0][N-1:0]       req_seed,
    input  logic [NUM_REQ-1:0][CNT_W-1:0]   req_steps,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_id,
    output logic [N-1:0]                    rsp_data,
    output logic                            rsp_wrapped,
    output logic                            rsp_err,
    output logic                            lfsr_load_seed,
    output logic [N-1:0]                    lfsr_seed_data,
    input  logic [N-1:0]                    lfsr_data_in,
    input  logic                            lfsr_done_in
);

    typedef struct packed {
        logic         id;
        logic [N-1:0] data;
        logic         wrapped;
        logic         err;
    } rsp_t;

    state_e           state_q, state_d;
    logic [N-1:0]     seed_q, seed_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             wrap_q, wrap_d;
    rsp_t             rsp_q, rsp_d;

    logic [NUM_REQ-1:0] grant;
    logic               advance;
    logic               grant_id;
    logic [N-1:0]       grant_seed;
    logic               wrap_now;

    lfsr_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    assign grant_id   = grant[1];
    assign grant_seed = req_seed[grant_id];
    assign advance    = (state_q == StIdle) && (|req) && !reset;
    assign req_ready  = advance ? grant : '0;

    always_comb begin
        state_d        = state_q;
        seed_d         = seed_q;
        steps_d        = steps_q;
        cnt_d          = cnt_q;
        id_d           = id_q;
        wrap_d         = wrap_q;
        rsp_d          = rsp_q;
        wrap_now       = 1'b0;
        lfsr_load_seed = 1'b0;
        lfsr_seed_data = '0;

        unique case (state_q)
            StIdle: begin
                if (advance) begin
                    id_d    = grant_id;
                    steps_d = req_steps[grant_id];
`ifdef LFSR_SCHED_ZSEED_FIX_EN
                    seed_d  = (grant_seed == '0) ? '1 : grant_seed;
                    state_d = StLoad;
`else
                    seed_d  = grant_seed;
                    if (grant_seed == '0) begin
                        rsp_d   = '{id: grant_id, data: '0, wrapped: 1'b0, err: 1'b1};
                        state_d = StResp;
                    end else begin
                        state_d = StLoad;
                    end
`endif
                end
            end
            StLoad: begin
                lfsr_load_seed = 1'b1;
                lfsr_seed_data = seed_q;
                cnt_d          = steps_q;
                wrap_d         = 1'b0;
                state_d        = StRun;
            end
            StRun: begin
                // cnt only equals steps in the first RUN cycle, where done reflects the load.
                wrap_now = wrap_q | (lfsr_done_in && (cnt_q != steps_q));
                wrap_d   = wrap_now;
                if (cnt_q == '0) begin
                    rsp_d   = '{id: id_q, data: lfsr_data_in, wrapped: wrap_now, err: 1'b0};
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            seed_q  <= '0;
            steps_q <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            wrap_q  <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            steps_q <= steps_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            wrap_q  <= wrap_d;
            rsp_q   <= rsp_d;
        end
    end

    assign rsp_valid   = (state_q == StResp);
    assign rsp_id      = rsp_q.id;
    assign rsp_data    = rsp_q.data;
    assign rsp_wrapped = rsp_q.wrapped;
    assign rsp_err     = rsp_q.err;

endmodule

// File: tb/tb_lfsr_sched.sv
// Self-checking bench for lfsr_sched with a 4-bit maximal-length LFSR (x^4+x^3+1) attached.
module tb_lfsr_sched;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req;
    logic [1:0][3:0] req_seed;
    logic [1:0][7:0] req_steps;
    logic [1:0]      req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [3:0]      rsp_data;
    logic            rsp_wrapped;
    logic            rsp_err;
    logic            lfsr_load_seed;
    logic [3:0]      lfsr_seed_data;
    logic [3:0]      lfsr_data_in;
    logic            lfsr_done_in;

    always #5 clk = ~clk;

    lfsr_sched #(.N(4), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_seed       (req_seed),
        .req_steps      (req_steps),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .rsp_wrapped    (rsp_wrapped),
        .rsp_err        (rsp_err),
        .lfsr_load_seed (lfsr_load_seed),
        .lfsr_seed_data (lfsr_seed_data),
        .lfsr_data_in   (lfsr_data_in),
        .lfsr_done_in   (lfsr_done_in)
    );

    // Attached LFSR: free-running, done when it comes back to the loaded seed.
    logic [3:0] lq    = 4'h1;
    logic [3:0] lseed = 4'h1;
    logic       lmoved = 1'b0;
    always @(posedge clk) begin
        if (lfsr_load_seed) begin
            lq     <= lfsr_seed_data;
            lseed  <= lfsr_seed_data;
            lmoved <= 1'b0;
        end else begin
            lq     <= {lq[2:0], lq[3] ^ lq[2]};
            lmoved <= 1'b1;
        end
    end
    assign lfsr_data_in = lq;
    assign lfsr_done_in = lmoved && (lq == lseed);

    int n_cmp = 0;
    int n_bad = 0;
    int load_cnt = 0;
    int seed_leak = 0;

    always @(negedge clk) begin
        if (lfsr_load_seed) load_cnt <= load_cnt + 1;
        if (!lfsr_load_seed && lfsr_seed_data != 4'h0) seed_leak <= seed_leak + 1;
    end

    // Reference: the 15-state orbit; advancing K steps is an index offset mod 15.
    logic [3:0] orbit [15];

    function automatic logic [3:0] model_adv(input logic [3:0] s, input int k);
        int idx = 0;
        for (int i = 0; i < 15; i++) if (orbit[i] == s) idx = i;
        return orbit[(idx + k) % 15];
    endfunction

    task automatic predict(input logic [3:0] seed, input int k, output logic [3:0] ed,
                           output logic ew, output logic ee, output int el, output int eld);
        if (seed == 4'h0) begin
`ifdef LFSR_SCHED_ZSEED_FIX_EN
            ed = model_adv(4'hF, k); ew = (k >= 15); ee = 1'b0; el = 3 + k; eld = 1;
`else
            ed = 4'h0; ew = 1'b0; ee = 1'b1; el = 1; eld = 0;
`endif
        end else begin
            ed = model_adv(seed, k); ew = (k >= 15); ee = 1'b0; el = 3 + k; eld = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 2'b00; rsp_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Starts and ends just after a negedge. pend: requester 1 is held high and must stay blocked.
    task automatic do_job(input int id, input logic [3:0] seed, input int k, input int hold,
                          input bit pend, input logic [3:0] ed, input logic ew, input logic ee,
                          input int elat, input int eloads, input string tag);
        int w;
        int loads0;
        bit stable;
        bit blocked;
        logic [6:0] snap;
        req[id] = 1'b1; req_seed[id] = seed; req_steps[id] = 8'(k);
        #1;
        w = 0;
        while (!req_ready[id] && w < 40) begin @(negedge clk); #1; w++; end
        check({tag, " accept"}, 32'(req_ready[id]), 32'd1);
        loads0  = load_cnt;
        blocked = 1'b0;
        @(negedge clk);
        req[id] = 1'b0;
        #1;
        w = 1;
        while (!rsp_valid && w < 400) begin
            if (pend && req_ready != 2'b00) blocked = 1'b1;
            @(negedge clk); #1; w++;
        end
        check({tag, " latency"}, w, elat);
        check({tag, " data"}, 32'(rsp_data), 32'(ed));
        check({tag, " id"}, 32'(rsp_id), 32'(id));
        check({tag, " wrapped"}, 32'(rsp_wrapped), 32'(ew));
        check({tag, " err"}, 32'(rsp_err), 32'(ee));
        snap   = {rsp_valid, rsp_id, rsp_data, rsp_wrapped ^ rsp_err};
        stable = 1'b1;
        repeat (hold) begin
            if (pend && req_ready != 2'b00) blocked = 1'b1;
            @(negedge clk); #1;
            if ({rsp_valid, rsp_id, rsp_data, rsp_wrapped ^ rsp_err} != snap) stable = 1'b0;
        end
        if (hold > 0) check({tag, " held stable"}, 32'(stable), 32'd1);
        if (pend && req_ready != 2'b00) blocked = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check({tag, " released"}, 32'(rsp_valid), 32'd0);
        check({tag, " load pulses"}, load_cnt - loads0, eloads);
        if (pend) begin
            check({tag, " pending blocked"}, 32'(blocked), 32'd0);
            check({tag, " pending granted"}, 32'(req_ready), 32'b10);
        end
    endtask

    typedef struct {
        int         id;
        logic [3:0] seed;
        int         k;
        int         hold;
        bit         pend;
        logic [3:0] d;
        logic       w;
        logic       e;
        int         lat;
        int         loads;
    } vec_t;

    vec_t tbl [8];

    int         wt;
    logic       gid;
    int         rid, rk, rhold, rlat, rld;
    logic [3:0] rseed, rd;
    logic       rw, re;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        orbit[0] = 4'h1;
        for (int i = 1; i < 15; i++) orbit[i] = {orbit[i-1][2:0], orbit[i-1][3] ^ orbit[i-1][2]};

        tbl[0] = '{0, 4'hF,   0, 0, 1'b0, 4'hF, 1'b0, 1'b0,   3, 1};
        tbl[1] = '{0, 4'h1,   5, 0, 1'b0, 4'h6, 1'b0, 1'b0,   8, 1};
`ifdef LFSR_SCHED_ZSEED_FIX_EN
        tbl[2] = '{1, 4'h0,   3, 0, 1'b0, 4'h8, 1'b0, 1'b0,   6, 1};
`else
        tbl[2] = '{1, 4'h0,   3, 0, 1'b0, 4'h0, 1'b0, 1'b1,   1, 0};
`endif
        tbl[3] = '{0, 4'hF,  20, 6, 1'b1, 4'h2, 1'b1, 1'b0,  23, 1};
        tbl[4] = '{1, 4'h1,  15, 0, 1'b0, 4'h1, 1'b1, 1'b0,  18, 1};
        tbl[5] = '{0, 4'h1,  14, 2, 1'b0, 4'h8, 1'b0, 1'b0,  17, 1};
        tbl[6] = '{1, 4'h9, 255, 0, 1'b0, 4'h9, 1'b1, 1'b0, 258, 1};
        tbl[7] = '{1, 4'hA,   1, 1, 1'b0, 4'h5, 1'b0, 1'b0,   4, 1};

        reset = 1'b1; req = 2'b00; req_seed = '0; req_steps = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset rsp_valid", 32'(rsp_valid), 0);
        check("reset rsp_data", 32'(rsp_data), 0);
        check("reset rsp_id", 32'(rsp_id), 0);
        check("reset rsp_err", 32'(rsp_err), 0);
        check("reset load_seed", 32'(lfsr_load_seed), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].pend) begin
                req[1] = 1'b1; req_seed[1] = 4'h3; req_steps[1] = 8'd2;
            end
            do_job(tbl[i].id, tbl[i].seed, tbl[i].k, tbl[i].hold, tbl[i].pend, tbl[i].d,
                   tbl[i].w, tbl[i].e, tbl[i].lat, tbl[i].loads, $sformatf("vec%0d", i));
            if (tbl[i].pend) do_job(1, 4'h3, 2, 0, 1'b0, 4'hD, 1'b0, 1'b0, 5, 1, "pend1");
        end

        // Both requesters held: strict alternation starting from requester 0.
        do_reset();
        req_seed[0] = 4'h5; req_steps[0] = 8'd3;
        req_seed[1] = 4'hC; req_steps[1] = 8'd7;
        req = 2'b11; rsp_ready = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            wt = 0;
            while (req_ready == 2'b00 && wt < 50) begin @(negedge clk); #1; wt++; end
            check($sformatf("rr grant %0d", j), 32'(req_ready), (j % 2 == 1) ? 32'b10 : 32'b01);
            gid = req_ready[1];
            wt = 0;
            while (!rsp_valid && wt < 300) begin @(negedge clk); #1; wt++; end
            check($sformatf("rr id %0d", j), 32'(rsp_id), 32'(gid));
            check($sformatf("rr data %0d", j), 32'(rsp_data),
                  32'(gid ? model_adv(4'hC, 7) : model_adv(4'h5, 3)));
            @(negedge clk); #1;
        end
        req = 2'b00; rsp_ready = 1'b0;
        @(negedge clk); @(negedge clk); #1;

        // Reset while RUN has cnt==3; the aborted job must never respond.
        do_reset();
        req[0] = 1'b1; req_seed[0] = 4'h1; req_steps[0] = 8'd6;
        #1;
        check("abort accept0", 32'(req_ready), 32'b01);
        @(negedge clk);
        req[0] = 1'b0; req[1] = 1'b1; req_seed[1] = 4'h9; req_steps[1] = 8'd2;
        repeat (4) @(negedge clk);
        #1;
        check("abort busy", 32'(rsp_valid), 0);
        reset = 1'b1;
        @(negedge clk); #1;
        check("abort outputs zero", 32'({req_ready, rsp_valid, rsp_id, rsp_data, rsp_wrapped,
                                         rsp_err, lfsr_load_seed, lfsr_seed_data}), 0);
        reset = 1'b0;
        #1;
        check("abort regrant", 32'(req_ready), 32'b10);
        do_job(1, 4'h9, 2, 0, 1'b0, model_adv(4'h9, 2), 1'b0, 1'b0, 5, 1, "post-reset");

        for (int r = 0; r < 12; r++) begin
            rid   = int'($urandom_range(0, 1));
            rseed = 4'($urandom_range(0, 15));
            rk    = int'($urandom_range(0, 40));
            rhold = int'($urandom_range(0, 3));
            predict(rseed, rk, rd, rw, re, rlat, rld);
            do_job(rid, rseed, rk, rhold, 1'b0, rd, rw, re, rlat, rld, $sformatf("rand%0d", r));
        end

        check("seed_data outside LOAD", seed_leak, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
